// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment patterns, blank code and scan phase type for the seg7 display blocks
package seg7_pkg;
  localparam logic [7:0] SEG7_BLANK = 8'hFF;
  localparam logic [15:0][6:0] SEG7_PAT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  typedef enum logic {BLANK, ON} phase_t;
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: one digit code to active-low {dp,g,f,e,d,c,b,a}
// Ports: code  - 0x0h shows hex digit h, any nonzero upper nibble is blank
//        seg   - active-low segments, dp always off
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [7:0] code,
  output logic [7:0] seg
);
  always_comb seg = code[7:4] != 4'h0 ? SEG7_BLANK : {1'b1, ~SEG7_PAT[code[3:0]]};
endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed 8-digit common-anode 7-segment scan driver with per-slot dead time
// Ports: csi_clk/csi_rst - clock, synchronous active-high reset
//        coe_SEG7        - byte k is digit k (digit 0 rightmost), sampled once per frame
//        coe_seg_sel     - active-low one-hot digit enable
//        coe_seg_data    - active-low segments {dp,g,f,e,d,c,b,a}
//        coe_frame       - one-cycle pulse following each snapshot of coe_SEG7
// Optional: SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown)
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int DEAD = 500
) (
  input  logic        csi_clk,
  input  logic        csi_rst,
  input  logic [63:0] coe_SEG7,
  output logic [7:0]  coe_seg_sel,
  output logic [7:0]  coe_seg_data,
  output logic        coe_frame
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DL = CW'(DEAD);
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [63:0] snap;
  logic [7:0] lz, code, seg;
  logic wrap, start;
  phase_t ph, ph_nxt;
  assign wrap = cnt == LAST;
  assign start = cnt == '0 && idx == 3'd0;
  // Phase register tracks what the pins show; select and segments only ever change under BLANK.
  always_comb ph_nxt = ph == ON ? (cnt == '0 ? BLANK : ON) : (cnt == DL ? ON : BLANK);
  always_comb begin
    lz = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    begin
      logic hi;
      hi = 1'b1;
      for (int k = 7; k >= 1; k--) begin
        lz[k] = hi && snap[8*k +: 8] == 8'h00;
        hi = hi && (snap[8*k +: 8] == 8'h00 || snap[8*k+4 +: 4] != 4'h0);
      end
    end
`endif
  end
  assign code = lz[idx] ? SEG7_BLANK : snap[8*idx +: 8];
  seg7_hex_decode u_dec (.code(code), .seg(seg));
  always_ff @(posedge csi_clk) begin
    if (csi_rst) begin
      cnt <= '0;
      idx <= 3'd0;
      snap <= '1;
      ph <= BLANK;
      coe_seg_sel <= 8'hFF;
      coe_seg_data <= SEG7_BLANK;
      coe_frame <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      idx <= idx + 3'(wrap);
      if (start) snap <= coe_SEG7;
      ph <= ph_nxt;
      coe_seg_sel <= ph_nxt == ON ? ~(8'd1 << idx) : 8'hFF;
      coe_seg_data <= ph_nxt == ON ? seg : SEG7_BLANK;
      coe_frame <= start;
    end
  end
endmodule

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed scan driver for the board's 8-digit common-anode 7-segment display. It consumes the 64-bit `coe_SEG7` conduit from the Avalon SEG7 register block. Each byte on that bus is either `0x0h` (show hex digit h) or `0xFF` (blank). The block decodes one digit at a time, drives the shared segment lines and the one-hot digit select, and inserts a dead-time gap between digits to suppress ghosting.

## Interface
- `CLK_DIV`, 50000: clock cycles per digit slot (1 kHz slot / 125 Hz frame at 50 MHz); must be ≥ 4.
- `DEAD`, 500: blank cycles at the start of each slot; 1 ≤ DEAD < CLK_DIV.
- `csi_clk` in 1: system clock.
- `csi_rst` in 1: synchronous reset, active-high.
- `coe_SEG7` in 64: digit codes; byte k (bits 8k+7:8k) is digit k, and digit 0 is rightmost.
- `coe_seg_sel` out 8: digit enables, active-low, at most one bit low.
- `coe_seg_data` out 8: segments {dp,g,f,e,d,c,b,a}, active-low; dp is always off (1).
- `coe_frame` out 1: one-cycle pulse when a new snapshot of `coe_SEG7` is taken.

## Operation
- State:
  - slot counter `cnt` 0..CLK_DIV-1;
  - digit index `idx` 0..7;
  - 64-bit snapshot register `snap`;
  - phase FSM {BLANK, ON}.
- `cnt` increments every cycle. At CLK_DIV-1 it wraps to 0 and `idx` increments, with 7 wrapping to 0.
- Phase:
  - BLANK while cnt < DEAD: `coe_seg_sel` = 8'hFF and `coe_seg_data` = 8'hFF.
  - ON while cnt ≥ DEAD: `coe_seg_sel` = ~(1<<idx) and `coe_seg_data` = decode(`snap` byte idx).
- Snapshot:
  - `snap` loads from `coe_SEG7` when cnt==0 and idx==0, and `coe_frame` pulses that cycle.
  - Input changes mid-frame never appear until the next frame, so there is no tearing.
- Decode (active-high gfedcba, then inverted):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- Any byte whose upper nibble is nonzero (including 0xFF) is blank, and drives `coe_seg_data` = 8'hFF.

## Timing
- Reset values (next edge after `csi_rst`=1):
  - `cnt`=0, `idx`=0, FSM=BLANK;
  - `snap`=64'hFFFF_FFFF_FFFF_FFFF;
  - `coe_seg_sel`=8'hFF, `coe_seg_data`=8'hFF, `coe_frame`=0.
- Outputs are registered, with one cycle of latency from the (cnt, idx) state to the pins.
- Snapshot timing:
  - The first snapshot is taken in the first cycle after reset deasserts (cnt==0, idx==0).
  - The snapshot is visible on the pins from the ON phase of digit 0 in that frame.
- Per slot: DEAD cycles all-off, then CLK_DIV−DEAD cycles on. The frame period is exactly 8·CLK_DIV cycles.
- Select and segment change only while both are blank, so no cycle ever shows digit k's segments with digit k±1's select.
- Reset asserted mid-slot blanks the outputs at the next edge and restarts at idx 0.

## Configuration
- `SEG7_LEADING_ZERO_BLANK_EN` defined:
  - Leading zeros are blanked. Digit k (k ≥ 1) is forced blank if its code is 0x00 and every higher digit is 0x00 or blank.
  - Digit 0 is never suppressed.
  - The suppression mask is computed from `snap` and applies to the whole frame.
- Undefined: every 0x00 digit shows "0".

## Structure
- Package `seg7_pkg`:
  - the 16 segment patterns as constants;
  - `SEG7_BLANK` = 8'hFF;
  - the phase enum {BLANK, ON}.
- Sub-module `seg7_hex_decode`: combinational, 8-bit code in, 8-bit active-low segments out (blank handling included).
- Top level holds the counters, FSM, snapshot, suppression mask and output registers.

## Test plan
- Sim parameters for all scenarios: CLK_DIV=16, DEAD=2.
- Reset, then `coe_SEG7`=64'h0001_0203_0405_0607:
  - digit 0 slot shows sel=8'hFE with seg=~07=8'hF8;
  - digit 7 slot shows sel=8'h7F with seg=~3F=8'hC0;
  - each slot has exactly 2 all-FF cycles;
  - `coe_frame` pulse every 128 cycles.
- All bytes 0xFF → `coe_seg_sel` ON patterns still rotate, and `coe_seg_data`=8'hFF throughout.
- Change `coe_SEG7` from all-0x0A to all-0x0F during digit 3's slot:
  - digits 3–7 still show A (8'h88) this frame;
  - all digits show F (8'h8E) from the next `coe_frame`.
- Byte 0x12 on digit 2 → blank, identical to 0xFF.
- Assert `csi_rst` at digit 5, cnt=9:
  - next edge: sel=seg=8'hFF, snap all-FF;
  - after deassert, digit 0 restarts and a snapshot is taken immediately.
- Leading zeros, input 64'h0000_0000_0000_0105:
  - with `SEG7_LEADING_ZERO_BLANK_EN`, digits 2–7 are blank and digits 1, 0 show "1", "5";
  - without it, digits 2–7 show "0" (8'hC0).
